// File: rtl/seg7_score_ctrl.sv
// rtl/seg7_score_ctrl.sv - score to 4-digit multiplexed 7-segment display controller
//
// Purpose: accepts a 14-bit binary score (saturated to 9999), converts it to
// BCD with a serial double-dabble engine, and scans the four digits onto a
// common-anode 7-segment display.
//
// Parameters:
//   REFRESH_DIV   clock cycles each digit is driven (minimum 2)
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high reset
//   value         binary score to display
//   value_valid   value offered this cycle
//   value_ready   block can accept a value this cycle (IDLE or reset)
//   disp_en       0 forces all anodes off
//   done          one-cycle pulse while new digits are being committed
//   an            active-low anodes, an[0] = ones, an[3] = thousands
//   seg           active-low segments gfedcba
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  blanks digits above the most significant
//                               nonzero digit (ones digit always shown)

module seg7_score_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        disp_en,
    output logic        done,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [13:0] bin;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [3:0]  bitcnt;
    logic [15:0] digits;
    logic [13:0] value_sat;

    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [3:0]    cur_digit;
    logic          lz_blank;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Conversion FSM
    // ---------------------------------------------------------------
    assign value_sat   = (value > 14'd9999) ? 14'd9999 : value;
    // reset is ORed in so the upstream sees ready even while the FSM is
    // being forced back to IDLE; the state register blocks the transfer.
    assign value_ready = (state == IDLE) | reset;
    assign done        = (state == COMMIT) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (value_valid) state_nx = SHIFT;
            SHIFT:   if (bitcnt == 4'd13) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // add-3 correction applied to every nibble before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin    <= '0;
            bcd    <= '0;
            bitcnt <= '0;
            digits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        bin    <= value_sat;
                        bcd    <= '0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd    <= {bcd_adj[14:0], bin[13]};
                    bin    <= {bin[12:0], 1'b0};
                    bitcnt <= bitcnt + 4'd1;
                end
                COMMIT: begin
                    digits <= bcd;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Display scan
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign cur_digit = digits[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // a digit is blank when it and every more significant digit are zero
    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd1:    lz_blank = (digits[15:4]  == 12'd0);
            2'd2:    lz_blank = (digits[15:8]  == 8'd0);
            2'd3:    lz_blank = (digits[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // an and seg come from the same idx in the same register stage so they
    // can never disagree about which digit is lit
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else if (!disp_en || lz_blank) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= dec7(cur_digit);
        end
    end

endmodule

// File: tb/tb_seg7_score_ctrl.sv
// tb/tb_seg7_score_ctrl.sv - directed self-checking bench for seg7_score_ctrl

module tb_seg7_score_ctrl;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        value_valid;
    logic        value_ready;
    logic        disp_en;
    logic        done;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_score_ctrl #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .disp_en     (disp_en),
        .done        (done),
        .an          (an),
        .seg         (seg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watch 24 cycles (one and a half scan periods) and check which digits
    // light up and with which pattern. A BL expectation means never lit.
    task automatic scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [6:0] e3);
        logic       seen [4];
        logic [6:0] sv   [4];
        logic [6:0] e    [4];
        int         conflicts;
        int         illegal;
        int         k;
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0;
            sv[i]   = BL;
        end
        conflicts = 0;
        illegal   = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            k = -1;
            case (an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                4'b1111: k = -1;
                default: illegal++;
            endcase
            if (k >= 0) begin
                if (seen[k] && sv[k] !== seg) conflicts++;
                seen[k] = 1'b1;
                sv[k]   = seg;
            end
        end
        chk({tag, ".conflict"}, conflicts, 0);
        chk({tag, ".illegal_an"}, illegal, 0);
        for (int i = 0; i < 4; i++) begin
            if (e[i] == BL) begin
                chk($sformatf("%s.d%0d_lit", tag, i), {31'd0, seen[i]}, 0);
            end else begin
                chk($sformatf("%s.d%0d_lit", tag, i), {31'd0, seen[i]}, 1);
                chk($sformatf("%s.d%0d_seg", tag, i), {25'd0, sv[i]}, {25'd0, e[i]});
            end
        end
    endtask

    // One transfer, then follow 20 cycles. Cycle c is sampled on the
    // negedge following the c-th rising edge counted from the transfer
    // edge (c = 1 is the first SHIFT cycle). A second offer can be made at
    // cycle second_at (0 = none).
    task automatic run_conv(input string tag, input logic [13:0] v, input int second_at);
        int done_at;
        int ndone;
        int ready_bad;
        @(negedge clk);
        chk({tag, ".ready_idle"}, {31'd0, value_ready}, 1);
        value       = v;
        value_valid = 1'b1;
        @(posedge clk);
        done_at   = 0;
        ndone     = 0;
        ready_bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            value_valid = 1'b0;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            if (value_ready !== (c >= 16)) ready_bad++;
            if (c == second_at) begin
                chk({tag, ".ready_busy"}, {31'd0, value_ready}, 0);
                value       = 14'd1234;
                value_valid = 1'b1;
            end
        end
        chk({tag, ".done_cycle"}, done_at, 15);
        chk({tag, ".done_count"}, ndone, 1);
        chk({tag, ".ready_profile"}, ready_bad, 0);
    endtask

    initial begin
        int nd;
        int an_bad;

        reset       = 1'b1;
        value       = 14'd0;
        value_valid = 1'b0;
        disp_en     = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.an", {28'd0, an}, 4'b1111);
        chk("rst.seg", {25'd0, seg}, BL);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.ready", {31'd0, value_ready}, 1);
        reset = 1'b0;

        // basic conversion and scan
        run_conv("v1234", 14'd1234, 0);
        scan("v1234", S4, S3, S2, S1);

        // display disabled for 20 cycles, then the scan resumes
        @(negedge clk);
        disp_en = 1'b0;
        an_bad  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (an !== 4'b1111) an_bad++;
        end
        chk("disp_off.an", an_bad, 0);
        disp_en = 1'b1;
        scan("disp_on", S4, S3, S2, S1);

        // saturation
        run_conv("v12000", 14'd12000, 0);
        scan("v12000", S9, S9, S9, S9);

        // zero
        run_conv("v0", 14'd0, 0);
        scan("v0", S0, LZ, LZ, LZ);

        // second offer while busy is ignored
        run_conv("v42", 14'd42, 5);
        scan("v42", S2, S4, LZ, LZ);

        // reset aborts a conversion in SHIFT
        @(negedge clk);
        value       = 14'd5678;
        value_valid = 1'b1;
        @(posedge clk);
        nd = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            value_valid = 1'b0;
            if (done) nd++;
        end
        reset       = 1'b1;
        value_valid = 1'b1;
        @(negedge clk);
        chk("abort.an", {28'd0, an}, 4'b1111);
        chk("abort.seg", {25'd0, seg}, BL);
        chk("abort.done", {31'd0, done}, 0);
        chk("abort.ready", {31'd0, value_ready}, 1);
        // one more edge with reset, IDLE and valid all high: no transfer
        @(negedge clk);
        reset       = 1'b0;
        value_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort.no_done", nd, 0);
        scan("abort", S0, LZ, LZ, LZ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_score_ctrl.md
SEG7_SCORE_CTRL -- requirements
Module: seg7_score_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value  input  14  binary score to display.
REQ-005 SHALL have port value_valid  input  1  value offered this cycle.
REQ-006 SHALL have port value_ready  output  1  block can accept value this cycle.
REQ-007 SHALL have port disp_en  input  1  0 forces all anodes off.
REQ-008 SHALL have port done  output  1  one-cycle pulse when new digits are committed to the display.
REQ-009 SHALL have port an  output  4  active-low digit anodes; an[0] = ones digit, an[3] = thousands digit.
REQ-010 SHALL have port seg  output  7  active-low segments gfedcba, same encoding as the team BCD-to-7-segment decoder (0 -> 1000000, 8 -> 0000000, blank -> 1111111).

Function
REQ-011 SHALL run a conversion FSM with states IDLE, SHIFT, COMMIT; value_ready = 1 only in IDLE.
REQ-012 SHALL perform a transfer on any edge where value_valid & value_ready; it captures value saturated to 9999 (value > 9999 -> 9999), clears the 16-bit BCD accumulator, and goes IDLE -> SHIFT.
REQ-013 SHALL, in SHIFT, perform one double-dabble step per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by 1; there are exactly 14 SHIFT cycles, then SHIFT -> COMMIT.
REQ-014 SHALL, in COMMIT, copy the 4 BCD nibbles into the display digit registers, assert done for that cycle only, and go COMMIT -> IDLE.
REQ-015 SHALL give a latency from the transfer edge to the done cycle of 15 cycles; value_ready returns to 1 on cycle 16.
REQ-016 SHALL ignore value_valid while not in IDLE; the display keeps showing the previously committed digits until COMMIT.
REQ-017 SHALL run a free-running divider counting 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index 0..3 advances, wrapping 3 -> 0.
REQ-018 SHALL register an and seg together, one cycle after the digit index changes; an = ~(1 << index) and seg = the decoded digit[index], so an and seg are never mismatched.
REQ-019 SHALL drive an = 1111 on the next registered update when disp_en = 0; the divider and digit index keep running and seg is don't-care.
REQ-020 SHALL, on a COMMIT occurring mid-scan, use the new digits at the next registered update without resetting the divider or digit index.
REQ-021 SHALL drive seg = 1111111 for any digit nibble > 9.

Reset
REQ-022 SHALL, while reset = 1 at an edge, set the state to IDLE, BCD accumulator, bit counter, digit registers, divider and digit index to 0, done to 0, an to 1111 and seg to 1111111.
REQ-023 SHALL let reset asserted during SHIFT or COMMIT abort the conversion; no done pulse is produced and the digits read 0000.
REQ-024 SHALL hold value_ready = 1 during reset, but no transfer occurs on an edge where reset = 1.

Configuration
REQ-025 SHALL, with macro SEG7_LEADING_ZERO_BLANK_EN defined, blank any digit above the most significant nonzero digit (an bit held 1, seg 1111111); digit 0 is always shown, so value 0 displays "0".
REQ-026 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, show all four digits including leading zeros (value 42 displays 0042).

Verification (REFRESH_DIV = 4)
REQ-027 SHALL cover: reset, then value 1234 with valid for one cycle -> done exactly 15 cycles after the transfer; scan yields an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001.
REQ-028 SHALL cover: value 12000 -> committed digits 9999; all anodes show seg 0010000.
REQ-029 SHALL cover: a second valid 5 cycles after transfer of 0042 -> value_ready = 0 and the second value is ignored; exactly one done pulse, digits 0042 (macro off) or only an[0]/an[1] active (macro on).
REQ-030 SHALL cover: reset pulsed 7 cycles into SHIFT of 5678 -> no done pulse, an = 1111 and seg = 1111111 on the reset edge, then digits 0000.
REQ-031 SHALL cover: disp_en held 0 for 20 cycles -> an = 1111 throughout; after release, the scan resumes at the current index with the correct digit.
REQ-032 SHALL cover: value 0 -> digit 0 shows seg 1000000 in both configurations; digits 1-3 blank only with the macro defined.
